// File: rtl/pcie_ltssm_pkg.sv
// ============================================================================
//  Module      : pcie_ltssm_pkg
//  Description : Shared types for the PCIe LTSSM sequencer: LTSSM state and
//                phase encodings, sub-state block indices and helpers that
//                map a state onto its sub-block enable/index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_ltssm_pkg;

  typedef enum logic [2:0] {
    DETECT   = 3'd0,
    POLLING  = 3'd1,
    CONFIG   = 3'd2,
    L0       = 3'd3,
    RECOVERY = 3'd4,
    DISABLED = 3'd5
  } ltssm_state_e;

  typedef enum logic [1:0] {
    ENTER   = 2'd0,
    RUN     = 2'd1,
    HANDOFF = 2'd2
  } ltssm_phase_e;

  localparam int NUM_SUB   = 5;
  localparam int SUB_IDX_W = 3;

  localparam logic [SUB_IDX_W-1:0] SUB_DET = 3'd0;
  localparam logic [SUB_IDX_W-1:0] SUB_POL = 3'd1;
  localparam logic [SUB_IDX_W-1:0] SUB_CFG = 3'd2;
  localparam logic [SUB_IDX_W-1:0] SUB_L0  = 3'd3;
  localparam logic [SUB_IDX_W-1:0] SUB_REC = 3'd4;

  // One-hot sub-block enable for a state; DISABLED owns no sub-block.
  function automatic logic [NUM_SUB-1:0] sub_onehot(input ltssm_state_e s);
    logic [NUM_SUB-1:0] oh;
    case (s)
      DETECT:   oh = 5'b00001;
      POLLING:  oh = 5'b00010;
      CONFIG:   oh = 5'b00100;
      L0:       oh = 5'b01000;
      RECOVERY: oh = 5'b10000;
      default:  oh = 5'b00000;
    endcase
    return oh;
  endfunction

  // Sub-block index (TX stream owner) for a state.
  function automatic logic [SUB_IDX_W-1:0] sub_index(input ltssm_state_e s);
    logic [SUB_IDX_W-1:0] idx;
    case (s)
      POLLING:  idx = SUB_POL;
      CONFIG:   idx = SUB_CFG;
      L0:       idx = SUB_L0;
      RECOVERY: idx = SUB_REC;
      default:  idx = SUB_DET;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltssm_axis_mux.sv
// ============================================================================
//  Module      : ltssm_axis_mux
//  Description : Packet-boundary N:1 AXI-Stream mux. The selected source is
//                passed straight through (no buffering) while pass_i is high;
//                in_pkt_o tracks whether a packet is open on the output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltssm_axis_mux #(
  parameter int NUM        = 5,
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 5,
  parameter int IDX_W      = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [IDX_W-1:0]          owner_i,
  input  logic                      pass_i,
  input  logic [NUM*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM*KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [NUM-1:0]            s_axis_tvalid_i,
  input  logic [NUM-1:0]            s_axis_tlast_i,
  input  logic [NUM*USER_WIDTH-1:0] s_axis_tuser_i,
  output logic [NUM-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]     m_axis_tkeep_o,
  output logic                      m_axis_tvalid_o,
  output logic                      m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]     m_axis_tuser_o,
  input  logic                      m_axis_tready_i,
  output logic                      in_pkt_o
);

  logic w_valid_sel;
  logic r_in_pkt;

  // Select the owner's stream and route ready back only to the owner.
  always_comb begin
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = '0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = '0;
    w_valid_sel     = 1'b0;
    s_axis_tready_o = '0;
    for (int i = 0; i < NUM; i++) begin
      if (owner_i == i[IDX_W-1:0]) begin
        m_axis_tdata_o     = s_axis_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep_o     = s_axis_tkeep_i[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast_o     = s_axis_tlast_i[i];
        m_axis_tuser_o     = s_axis_tuser_i[i*USER_WIDTH +: USER_WIDTH];
        w_valid_sel        = s_axis_tvalid_i[i];
        s_axis_tready_o[i] = m_axis_tready_i & pass_i;
      end
    end
  end

  assign m_axis_tvalid_o = pass_i & w_valid_sel;
  assign in_pkt_o        = r_in_pkt;

  // Open a packet on a non-last accepted beat, close it on the last one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_pkt <= 1'b0;
    end else if (m_axis_tvalid_o && m_axis_tready_i) begin
      r_in_pkt <= ~m_axis_tlast_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ltssm_controller.sv
// ============================================================================
//  Module      : ltssm_controller
//  Description : PCIe LTSSM sequencer. Enables one sub-state block at a time,
//                consumes its success/error results, applies a per-state
//                timeout and shares the TX stream between sub-blocks,
//                changing owner only on packet boundaries.
//                Optional build macro LTSSM_TRACE_EN adds state-change trace
//                outputs and a saturating L0->Recovery counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltssm_controller
  import pcie_ltssm_pkg::*;
#(
  parameter int MAX_NUM_LANES  = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 3000000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic [NUM_SUB-1:0]            sub_en_o,
  input  logic [NUM_SUB-1:0]            sub_success_i,
  input  logic [NUM_SUB-1:0]            sub_error_i,
  input  logic                          cfg_error_disable_i,
  input  logic                          disable_exit_i,
  output logic [2:0]                    ltssm_state_o,
  output logic                          link_up_o,
  input  logic [MAX_NUM_LANES-1:0]      lanes_active_i,
  output logic [MAX_NUM_LANES-1:0]      lanes_active_o,
  input  logic [NUM_SUB*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_SUB*KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [NUM_SUB-1:0]            s_axis_tvalid_i,
  input  logic [NUM_SUB-1:0]            s_axis_tlast_i,
  input  logic [NUM_SUB*USER_WIDTH-1:0] s_axis_tuser_i,
  output logic [NUM_SUB-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep_o,
  output logic                          m_axis_tvalid_o,
  output logic                          m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]         m_axis_tuser_o,
  input  logic                          m_axis_tready_i
`ifdef LTSSM_TRACE_EN
  ,
  output logic                          trace_valid_o,
  output logic [2:0]                    trace_prev_o,
  output logic [2:0]                    trace_next_o,
  output logic [15:0]                   recovery_count_o
`endif
);

  localparam logic [31:0] c_timeout_last =
    (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  ltssm_state_e              r_state, r_target;
  ltssm_phase_e              r_phase;
  logic [SUB_IDX_W-1:0]      r_owner;
  logic [31:0]               r_timer;
  logic [NUM_SUB-1:0]        r_sub_en;
  logic                      r_link_up;
  logic [MAX_NUM_LANES-1:0]  r_lanes;

  ltssm_state_e              w_state_n, w_target_n, w_dest;
  ltssm_phase_e              w_phase_n;
  logic [SUB_IDX_W-1:0]      w_owner_n;
  logic [NUM_SUB-1:0]        w_active;
  logic                      w_timeout, w_succ, w_err, w_result, w_cfg_ok;
  logic                      w_in_pkt, w_pass;

  // Only the active sub-block's result counts; a timeout is an error.
  assign w_active  = sub_onehot(r_state);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_phase == RUN) &&
                     (r_state != L0) && (r_state != DISABLED) &&
                     (r_timer == c_timeout_last);
  assign w_succ    = |(sub_success_i & w_active);
  assign w_err     = (|(sub_error_i & w_active)) | w_timeout;
  assign w_cfg_ok  = (r_phase == RUN) && (r_state == CONFIG) &&
                     !cfg_error_disable_i && !w_err && w_succ;

  // Result -> destination state; error beats success, disable beats all.
  always_comb begin
    w_result = 1'b0;
    w_dest   = DETECT;
    case (r_state)
      DETECT: begin
        if (w_err)       begin w_result = 1'b1; w_dest = DETECT;  end
        else if (w_succ) begin w_result = 1'b1; w_dest = POLLING; end
      end
      POLLING: begin
        if (w_err)       begin w_result = 1'b1; w_dest = DETECT; end
        else if (w_succ) begin w_result = 1'b1; w_dest = CONFIG; end
      end
      CONFIG: begin
        if (cfg_error_disable_i) begin w_result = 1'b1; w_dest = DISABLED; end
        else if (w_err)          begin w_result = 1'b1; w_dest = DETECT;   end
        else if (w_succ)         begin w_result = 1'b1; w_dest = L0;       end
      end
      L0: begin
        if (w_err) begin w_result = 1'b1; w_dest = RECOVERY; end
      end
      RECOVERY: begin
        if (w_err)       begin w_result = 1'b1; w_dest = DETECT; end
        else if (w_succ) begin w_result = 1'b1; w_dest = L0;     end
      end
      default: begin
        w_result = 1'b0;
        w_dest   = DETECT;
      end
    endcase
  end

  // Phase sequencing: ENTER -> RUN -> HANDOFF (drain open packet) -> ENTER.
  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_target_n = r_target;
    w_owner_n  = r_owner;
    case (r_phase)
      ENTER: w_phase_n = RUN;
      RUN: begin
        if (r_state == DISABLED) begin
          if (disable_exit_i) begin
            w_state_n = DETECT;
            w_phase_n = ENTER;
            w_owner_n = SUB_DET;
          end
        end else if (w_result) begin
          w_phase_n  = HANDOFF;
          w_target_n = w_dest;
        end
      end
      HANDOFF: begin
        if (!w_in_pkt) begin
          w_state_n = r_target;
          w_phase_n = ENTER;
          if (r_target != DISABLED) w_owner_n = sub_index(r_target);
        end
      end
      default: w_phase_n = ENTER;
    endcase
  end

  // Stream flows in RUN, and during HANDOFF only to finish an open packet.
  assign w_pass = ((r_phase == RUN) && (r_state != DISABLED)) ||
                  ((r_phase == HANDOFF) && w_in_pkt);

  // LTSSM state register with registered enables, link-up, lanes and timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= DETECT;
      r_phase   <= ENTER;
      r_target  <= DETECT;
      r_owner   <= SUB_DET;
      r_timer   <= '0;
      r_sub_en  <= '0;
      r_link_up <= 1'b0;
      r_lanes   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_phase  <= w_phase_n;
      r_target <= w_target_n;
      r_owner  <= w_owner_n;
      if (r_phase == ENTER) begin
        r_timer <= '0;
      end else if ((r_phase == RUN) && (r_timer != '1)) begin
        r_timer <= r_timer + 32'd1;
      end
      // Enable follows the phase by one cycle and drops as soon as RUN ends.
      r_sub_en  <= ((r_phase == RUN) && (w_phase_n == RUN)) ? w_active : '0;
      r_link_up <= (w_state_n == L0) && (w_phase_n == RUN);
      if (w_cfg_ok) r_lanes <= lanes_active_i;
    end
  end

  assign sub_en_o       = r_sub_en;
  assign ltssm_state_o  = r_state;
  assign link_up_o      = r_link_up;
  assign lanes_active_o = r_lanes;

  ltssm_axis_mux #(
    .NUM        (NUM_SUB),
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .IDX_W      (SUB_IDX_W)
  ) u_mux (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .owner_i         (r_owner),
    .pass_i          (w_pass),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tkeep_i  (s_axis_tkeep_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tuser_i  (s_axis_tuser_i),
    .s_axis_tready_o (s_axis_tready_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tkeep_o  (m_axis_tkeep_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tuser_o  (m_axis_tuser_o),
    .m_axis_tready_i (m_axis_tready_i),
    .in_pkt_o        (w_in_pkt)
  );

`ifdef LTSSM_TRACE_EN
  logic        r_trace_valid;
  logic [2:0]  r_trace_prev, r_trace_next;
  logic [15:0] r_recovery_count;

  // Record every state change and count L0 -> Recovery entries (saturating).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trace_valid    <= 1'b0;
      r_trace_prev     <= DETECT;
      r_trace_next     <= DETECT;
      r_recovery_count <= '0;
    end else begin
      r_trace_valid <= (w_state_n != r_state);
      if (w_state_n != r_state) begin
        r_trace_prev <= r_state;
        r_trace_next <= w_state_n;
      end
      if ((r_state == L0) && (w_state_n == RECOVERY) && (r_recovery_count != 16'hFFFF))
        r_recovery_count <= r_recovery_count + 16'd1;
    end
  end

  assign trace_valid_o    = r_trace_valid;
  assign trace_prev_o     = r_trace_prev;
  assign trace_next_o     = r_trace_next;
  assign recovery_count_o = r_recovery_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ltssm_controller.sv
// ============================================================================
//  Module      : tb_ltssm_controller
//  Description : Directed self-checking bench for ltssm_controller
//                (TIMEOUT_CYCLES = 100).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ltssm_controller;
  import pcie_ltssm_pkg::*;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 5;
  localparam int NL = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [4:0]        sub_en_o, sub_success_i, sub_error_i;
  logic              cfg_error_disable_i, disable_exit_i;
  logic [2:0]        ltssm_state_o;
  logic              link_up_o;
  logic [NL-1:0]     lanes_active_i, lanes_active_o;
  logic [5*DW-1:0]   s_axis_tdata_i;
  logic [5*KW-1:0]   s_axis_tkeep_i;
  logic [4:0]        s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
  logic [5*UW-1:0]   s_axis_tuser_i;
  logic [DW-1:0]     m_axis_tdata_o;
  logic [KW-1:0]     m_axis_tkeep_o;
  logic              m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i;
  logic [UW-1:0]     m_axis_tuser_o;
`ifdef LTSSM_TRACE_EN
  logic              trace_valid_o;
  logic [2:0]        trace_prev_o, trace_next_o;
  logic [15:0]       recovery_count_o;
`endif

  int total = 0;
  int bad   = 0;
  int n_pol;

  always #5 clk = ~clk;

  ltssm_controller #(
    .MAX_NUM_LANES (NL),
    .DATA_WIDTH    (DW),
    .KEEP_WIDTH    (KW),
    .USER_WIDTH    (UW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .sub_en_o            (sub_en_o),
    .sub_success_i       (sub_success_i),
    .sub_error_i         (sub_error_i),
    .cfg_error_disable_i (cfg_error_disable_i),
    .disable_exit_i      (disable_exit_i),
    .ltssm_state_o       (ltssm_state_o),
    .link_up_o           (link_up_o),
    .lanes_active_i      (lanes_active_i),
    .lanes_active_o      (lanes_active_o),
    .s_axis_tdata_i      (s_axis_tdata_i),
    .s_axis_tkeep_i      (s_axis_tkeep_i),
    .s_axis_tvalid_i     (s_axis_tvalid_i),
    .s_axis_tlast_i      (s_axis_tlast_i),
    .s_axis_tuser_i      (s_axis_tuser_i),
    .s_axis_tready_o     (s_axis_tready_o),
    .m_axis_tdata_o      (m_axis_tdata_o),
    .m_axis_tkeep_o      (m_axis_tkeep_o),
    .m_axis_tvalid_o     (m_axis_tvalid_o),
    .m_axis_tlast_o      (m_axis_tlast_o),
    .m_axis_tuser_o      (m_axis_tuser_o),
    .m_axis_tready_i     (m_axis_tready_i)
`ifdef LTSSM_TRACE_EN
    ,
    .trace_valid_o       (trace_valid_o),
    .trace_prev_o        (trace_prev_o),
    .trace_next_o        (trace_next_o),
    .recovery_count_o    (recovery_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until sub_en_o shows the expected enable.
  task automatic wait_en(input logic [4:0] exp, input string tag);
    int n = 0;
    while (sub_en_o !== exp && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sub_en_o, exp);
  endtask

  // One-cycle result pulse, sampled by the following posedge.
  task automatic pulse(input logic [4:0] s, input logic [4:0] e);
    sub_success_i = s;
    sub_error_i   = e;
    @(negedge clk);
    sub_success_i = '0;
    sub_error_i   = '0;
  endtask

  task automatic drive(input int i, input logic [DW-1:0] d, input logic v, input logic l);
    s_axis_tdata_i[i*DW +: DW] = d;
    s_axis_tvalid_i[i]         = v;
    s_axis_tlast_i[i]          = l;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    sub_success_i = '0; sub_error_i = '0;
    cfg_error_disable_i = 1'b0; disable_exit_i = 1'b0;
    lanes_active_i = 4'b1111;
    s_axis_tdata_i = '0; s_axis_tkeep_i = '1; s_axis_tuser_i = '0;
    s_axis_tvalid_i = 5'b11111; s_axis_tlast_i = 5'b11111;
    m_axis_tready_i = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state: even with every source valid and ready high nothing passes.
    chk("rst_state",  ltssm_state_o, DETECT);
    chk("rst_sub_en", sub_en_o, 5'b00000);
    chk("rst_link",   link_up_o, 1'b0);
    chk("rst_lanes",  lanes_active_o, 4'b0000);
    chk("rst_tvalid", m_axis_tvalid_o, 1'b0);
    chk("rst_tready", s_axis_tready_o, 5'b00000);
    s_axis_tvalid_i = '0;

    // Test 1: bring-up DET -> POL -> CFG -> L0; enable 2 cycles after reset release.
    rst_i = 1'b0;
    @(negedge clk);
    chk("t1_en_c1", sub_en_o, 5'b00000);
    @(negedge clk);
    chk("t1_en_c2", sub_en_o, 5'b00001);
    pulse(5'b00001, 5'b00000);
    wait_en(5'b00010, "t1_en_pol");
    chk("t1_state_pol", ltssm_state_o, POLLING);
    pulse(5'b00010, 5'b00000);
    wait_en(5'b00100, "t1_en_cfg");
    pulse(5'b00100, 5'b00000);
    chk("t1_lanes", lanes_active_o, 4'b1111);
    chk("t1_link_cfg", link_up_o, 1'b0);
    wait_en(5'b01000, "t1_en_l0");
    chk("t1_state_l0", ltssm_state_o, L0);
    chk("t1_link_l0", link_up_o, 1'b1);

    // Test 4: L0 error -> REC; simultaneous success+error in REC -> DETECT.
    pulse(5'b00000, 5'b01000);
    wait_en(5'b10000, "t4_en_rec");
    chk("t4_state_rec", ltssm_state_o, RECOVERY);
    chk("t4_link_rec", link_up_o, 1'b0);
    pulse(5'b10000, 5'b10000);
    chk("t4_handoff_en", sub_en_o, 5'b00000);
    @(negedge clk);
    chk("t4_state_det", ltssm_state_o, DETECT);

    // Test 2: POL timeout after 100 RUN cycles (99 with enable up).
    wait_en(5'b00001, "t2_en_det");
    pulse(5'b00001, 5'b00000);
    wait_en(5'b00010, "t2_en_pol");
    n_pol = 0;
    while (sub_en_o === 5'b00010 && n_pol < 200) begin
      n_pol++;
      @(negedge clk);
    end
    chk("t2_pol_cycles", n_pol, 99);
    chk("t2_handoff_state", ltssm_state_o, POLLING);
    @(negedge clk);
    chk("t2_state_det", ltssm_state_o, DETECT);
    @(negedge clk);
    chk("t2_en_c1", sub_en_o, 5'b00000);
    @(negedge clk);
    chk("t2_en_c2", sub_en_o, 5'b00001);

    // Test 3: CFG packet in flight across CFG success; ready toggles.
    pulse(5'b00001, 5'b00000);
    wait_en(5'b00010, "t3_en_pol");
    pulse(5'b00010, 5'b00000);
    wait_en(5'b00100, "t3_en_cfg");
    lanes_active_i = 4'b0011;
    drive(2, 32'hA1, 1'b1, 1'b0);
    drive(3, 32'hD3, 1'b1, 1'b1);
    m_axis_tready_i = 1'b1;
    #1;
    chk("t3_b1_valid", m_axis_tvalid_o, 1'b1);
    chk("t3_b1_data",  m_axis_tdata_o, 32'hA1);
    chk("t3_b1_ready", s_axis_tready_o, 5'b00100);
    @(negedge clk);
    drive(2, 32'hA2, 1'b1, 1'b0);
    m_axis_tready_i = 1'b0;
    sub_success_i = 5'b00100;
    #1;
    chk("t3_b2_stall_ready", s_axis_tready_o, 5'b00000);
    @(negedge clk);
    sub_success_i = '0;
    m_axis_tready_i = 1'b1;
    #1;
    chk("t3_b2_state", ltssm_state_o, CONFIG);
    chk("t3_b2_en",    sub_en_o, 5'b00000);
    chk("t3_b2_data",  m_axis_tdata_o, 32'hA2);
    chk("t3_b2_valid", m_axis_tvalid_o, 1'b1);
    chk("t3_b2_ready", s_axis_tready_o, 5'b00100);
    @(negedge clk);
    drive(2, 32'hA3, 1'b1, 1'b1);
    m_axis_tready_i = 1'b0;
    #1;
    chk("t3_b3_stall_valid", m_axis_tvalid_o, 1'b1);
    chk("t3_b3_stall_ready", s_axis_tready_o, 5'b00000);
    @(negedge clk);
    m_axis_tready_i = 1'b1;
    #1;
    chk("t3_b3_data",  m_axis_tdata_o, 32'hA3);
    chk("t3_b3_last",  m_axis_tlast_o, 1'b1);
    chk("t3_b3_ready", s_axis_tready_o, 5'b00100);
    @(negedge clk);
    drive(2, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t3_gap_valid", m_axis_tvalid_o, 1'b0);
    chk("t3_gap_ready", s_axis_tready_o, 5'b00000);
    @(negedge clk);
    chk("t3_enter_l0", ltssm_state_o, L0);
    chk("t3_enter_valid", m_axis_tvalid_o, 1'b0);
    @(negedge clk);
    chk("t3_l0_valid", m_axis_tvalid_o, 1'b1);
    chk("t3_l0_data",  m_axis_tdata_o, 32'hD3);
    chk("t3_l0_ready", s_axis_tready_o, 5'b01000);
    chk("t3_lanes",    lanes_active_o, 4'b0011);
    drive(3, 32'h0, 1'b0, 1'b0);

    // Test 5: disable request wins over CFG success; exit returns to DETECT.
    pulse(5'b00000, 5'b01000);
    wait_en(5'b10000, "t5_en_rec");
    pulse(5'b00000, 5'b10000);
    wait_en(5'b00001, "t5_en_det");
    pulse(5'b00001, 5'b00000);
    wait_en(5'b00010, "t5_en_pol");
    pulse(5'b00010, 5'b00000);
    wait_en(5'b00100, "t5_en_cfg");
    lanes_active_i = 4'b1000;
    cfg_error_disable_i = 1'b1;
    pulse(5'b00100, 5'b00000);
    cfg_error_disable_i = 1'b0;
    drive(2, 32'hC0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_state_dis", ltssm_state_o, DISABLED);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_dis_en",     sub_en_o, 5'b00000);
    chk("t5_dis_valid",  m_axis_tvalid_o, 1'b0);
    chk("t5_dis_ready",  s_axis_tready_o, 5'b00000);
    chk("t5_dis_lanes",  lanes_active_o, 4'b0011);
    chk("t5_dis_link",   link_up_o, 1'b0);
    drive(2, 32'h0, 1'b0, 1'b0);
    disable_exit_i = 1'b1;
    @(negedge clk);
    disable_exit_i = 1'b0;
    chk("t5_exit_state", ltssm_state_o, DETECT);
    wait_en(5'b00001, "t5_en_det2");

    // Test 6: reset mid-packet in L0.
    pulse(5'b00001, 5'b00000);
    wait_en(5'b00010, "t6_en_pol");
    pulse(5'b00010, 5'b00000);
    wait_en(5'b00100, "t6_en_cfg");
    pulse(5'b00100, 5'b00000);
    wait_en(5'b01000, "t6_en_l0");
    drive(3, 32'hE1, 1'b1, 1'b0);
    #1;
    chk("t6_b1_ready", s_axis_tready_o, 5'b01000);
`ifdef LTSSM_TRACE_EN
    chk("t6_rec_count", recovery_count_o, 16'd2);
`endif
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("t6_rst_state",  ltssm_state_o, DETECT);
    chk("t6_rst_en",     sub_en_o, 5'b00000);
    chk("t6_rst_link",   link_up_o, 1'b0);
    chk("t6_rst_lanes",  lanes_active_o, 4'b0000);
    chk("t6_rst_valid",  m_axis_tvalid_o, 1'b0);
    chk("t6_rst_ready",  s_axis_tready_o, 5'b00000);
`ifdef LTSSM_TRACE_EN
    chk("t6_rst_rec_count", recovery_count_o, 16'd0);
`endif
    drive(3, 32'h0, 1'b0, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("t6_en_c1", sub_en_o, 5'b00000);
    @(negedge clk);
    chk("t6_en_c2", sub_en_o, 5'b00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
